d_key_generator: RTL and testbench

D_KEY_GENERATOR -- requirements
Module: d_key_generator

---
 rtl/d_key_generator.sv | 160 ++++++++++++++++
 tb/tb_d_key_generator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/d_key_generator.sv
// Private-exponent generator: d = e^-1 mod phi via extended Euclid.
// One quotient bit per cycle; only the t coefficient is tracked.
module d_key_generator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0] phi,
    output logic             busy,
    output logic             valid,
    output logic             error,
    output logic [WIDTH-1:0] d_key
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FINISH,
        DONE,
        FAIL
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t state, state_n;

    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      r0, r1, q, rem, phi_c;
    logic signed [WIDTH:0] t0, t1;

    logic [WIDTH:0]        rem_sh;
    logic [WIDTH-1:0]      rem_sub;
    logic                  fits;
    logic                  div_last;

    logic signed [2*WIDTH+1:0] q_ext, t0_ext, t1_ext;
    logic signed [WIDTH:0]     t_next;

    logic                  ok;
    logic [WIDTH-1:0]      d_res, d_fin;

    logic                  busy_d, valid_d, error_d;
    logic [WIDTH-1:0]      d_d;

    // Restoring step: dividend bits shift out of q while quotient bits shift in.
    always_comb begin
        rem_sh   = {rem, q[WIDTH-1]};
        fits     = rem_sh >= {1'b0, r1};
        rem_sub  = rem_sh[WIDTH-1:0] - r1;
        div_last = cnt == CW'(WIDTH - 1);
    end

    always_comb begin
        q_ext  = {{(WIDTH+2){1'b0}}, q};
        t0_ext = {{(WIDTH+1){t0[WIDTH]}}, t0};
        t1_ext = {{(WIDTH+1){t1[WIDTH]}}, t1};
        t_next = (WIDTH+1)'(t0_ext - q_ext * t1_ext);
    end

    // |t0| <= phi, so a negative t0 folds into [0, phi) with one add.
    always_comb begin
        ok    = (r0 == WIDTH'(1)) && (phi_c != '0);
        d_res = t0[WIDTH] ? t0[WIDTH-1:0] + phi_c : t0[WIDTH-1:0];
        d_fin = (phi_c == WIDTH'(1)) ? '0 : d_res;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en) state_n = CHECK;
            CHECK:   state_n = (r1 == '0) ? FINISH : DIV;
            DIV:     if (div_last) state_n = UPDATE;
            UPDATE:  state_n = CHECK;
            FINISH:  state_n = ok ? DONE : FAIL;
            DONE:    state_n = DONE;
            FAIL:    state_n = FAIL;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = busy;
        valid_d = valid;
        error_d = error;
        d_d     = d_key;
        unique case (state)
            IDLE:               busy_d = en;
            CHECK, DIV, UPDATE: busy_d = 1'b1;
            FINISH: begin
                busy_d  = 1'b0;
                valid_d = ok;
                error_d = !ok;
                d_d     = ok ? d_fin : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0    <= '0;
            r1    <= '0;
            t0    <= '0;
            t1    <= '0;
            q     <= '0;
            rem   <= '0;
            cnt   <= '0;
            phi_c <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            error <= 1'b0;
            d_key <= '0;
        end else begin
            busy  <= busy_d;
            valid <= valid_d;
            error <= error_d;
            d_key <= d_d;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        r0    <= phi;
                        r1    <= e_key;
                        t0    <= '0;
                        t1    <= (WIDTH+1)'(1);
                        phi_c <= phi;
                    end
                end
                CHECK: begin
                    if (r1 != '0) begin
                        q   <= r0;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    rem <= fits ? rem_sub : rem_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], fits};
                    cnt <= cnt + CW'(1);
                end
                UPDATE: begin
                    r0 <= r1;
                    r1 <= rem;
                    t0 <= t1;
                    t1 <= t_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_d_key_generator.sv
// Bench for d_key_generator: directed cases at WIDTH=32, random
// regression at WIDTH=8, both against an extended-Euclid model.
module tb_d_key_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, busy_a, valid_a, error_a;
    logic [31:0] e_a, phi_a, d_a;
    logic        rst_b, en_b, busy_b, valid_b, error_b;
    logic [7:0]  e_b, phi_b, d_b;

    d_key_generator #(.WIDTH(32)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .e_key(e_a), .phi(phi_a),
        .busy(busy_a), .valid(valid_a), .error(error_a), .d_key(d_a)
    );

    d_key_generator #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .e_key(e_b), .phi(phi_b),
        .busy(busy_b), .valid(valid_b), .error(error_b), .d_key(d_b)
    );

    int unsigned ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int errors = 0;
    int checks = 0;

    // mode: 0 = unchecked, 1 = idle (all zero), 2 = computation running
    int     mode  [2];
    int     start [2];
    int     lat   [2];
    bit     xok   [2];
    longint xd    [2];

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge count %0d)",
                     name, act, exp, ecnt);
        end
    endfunction

    // Extended Euclid on plain integers; n counts loop iterations.
    function automatic void model(input longint e, input longint p,
                                  output longint d, output bit ok,
                                  output int n);
        longint r0, r1, t0, t1, qq, tmp;
        r0 = p; r1 = e; t0 = 0; t1 = 1; n = 0;
        while (r1 != 0) begin
            qq = r0 / r1;
            tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
            tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
            n++;
        end
        ok = (r0 == 1) && (p != 0);
        d  = ok ? ((t0 % p) + p) % p : 0;
    endfunction

    function automatic longint gcd(input longint a, input longint b);
        longint x, y, tmp;
        x = a; y = b;
        while (y != 0) begin
            tmp = x % y; x = y; y = tmp;
        end
        return x;
    endfunction

    function automatic longint mulmod(input longint a, input longint b,
                                      input longint p);
        longint unsigned ua, ub;
        ua = longint'(a % p);
        ub = longint'(b);
        return longint'((ua * ub) % longint'(p));
    endfunction

    task automatic compare_one(input int i);
        bit b, v, er;
        longint d;
        int k;
        string nm;
        if (i == 0) begin
            b = busy_a; v = valid_a; er = error_a; d = longint'(d_a);
        end else begin
            b = busy_b; v = valid_b; er = error_b; d = longint'(d_b);
        end
        nm = (i == 0) ? "w32" : "w8";
        k = int'(ecnt) - start[i] - 1;
        if (mode[i] == 1 || (mode[i] == 2 && k < 0)) begin
            chk({nm, " idle busy"},  longint'(b),  0);
            chk({nm, " idle valid"}, longint'(v),  0);
            chk({nm, " idle error"}, longint'(er), 0);
            chk({nm, " idle d_key"}, d,            0);
        end else if (mode[i] == 2) begin
            if (k >= lat[i]) begin
                chk({nm, " done busy"},  longint'(b),  0);
                chk({nm, " done valid"}, longint'(v),  longint'(xok[i]));
                chk({nm, " done error"}, longint'(er), longint'(!xok[i]));
                chk({nm, " done d_key"}, d,            xd[i]);
            end else begin
                if (k >= 1) chk({nm, " run busy"}, longint'(b), 1);
                chk({nm, " run valid"}, longint'(v),  0);
                chk({nm, " run error"}, longint'(er), 0);
                chk({nm, " run d_key"}, d,            0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) compare_one(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1; en_a = 1'b1; mode[0] = 0;
        tick();
        rst_a = 1'b0; en_a = 1'b0; mode[0] = 1;
    endtask

    task automatic start_a(input longint e, input longint p);
        int n;
        model(e, p, xd[0], xok[0], n);
        lat[0] = n * 34 + 2;
        e_a = 32'(e); phi_a = 32'(p); en_a = 1'b1;
        start[0] = int'(ecnt); mode[0] = 2;
        tick();
    endtask

    task automatic run_a(input longint e, input longint p, input int extra,
                         input longint lit_d, input int lit_ok,
                         input int lit_n);
        longint md;
        bit mok;
        int n;
        model(e, p, md, mok, n);
        if (lit_d >= 0)  chk("model d", md, lit_d);
        if (lit_ok >= 0) chk("model ok", longint'(mok), longint'(lit_ok));
        if (lit_n >= 0)  chk("model n", longint'(n), longint'(lit_n));
        start_a(e, p);
        repeat (lat[0] + extra) begin
            en_a = 1'($urandom); e_a = $urandom; phi_a = $urandom;
            tick();
        end
        if (lit_d >= 0)  chk("w32 d_key literal", longint'(d_a), lit_d);
        if (lit_ok >= 0) chk("w32 valid literal", longint'(valid_a),
                             longint'(lit_ok));
        if (valid_a && p > 1)
            chk("w32 inverse", mulmod(e, longint'(d_a), p), 1);
        reset_a();
    endtask

    task automatic run_b(input longint e, input longint p);
        int n;
        model(e, p, xd[1], xok[1], n);
        lat[1] = n * 10 + 2;
        e_b = 8'(e); phi_b = 8'(p); en_b = 1'b1;
        start[1] = int'(ecnt); mode[1] = 2;
        tick();
        repeat (lat[1]) begin
            en_b = 1'($urandom); e_b = 8'($urandom); phi_b = 8'($urandom);
            tick();
        end
        chk("w8 valid iff gcd 1", longint'(valid_b),
            longint'(gcd(e, p) == 1));
        if (valid_b) chk("w8 inverse", mulmod(e, longint'(d_b), p), 1);
        rst_b = 1'b1; en_b = 1'b1; mode[1] = 0;
        tick();
        rst_b = 1'b0; en_b = 1'b0; mode[1] = 1;
    endtask

    initial begin
        mode[0] = 0; mode[1] = 0;
        start[0] = 0; start[1] = 0;
        rst_a = 1'b1; en_a = 1'b0; e_a = '0; phi_a = '0;
        rst_b = 1'b1; en_b = 1'b0; e_b = '0; phi_b = '0;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        mode[0] = 1; mode[1] = 1;
        e_a = 32'd99; phi_a = 32'd7;
        repeat (3) tick();

        run_a(3, 20, 3, 7, 1, 3);
        run_a(17, 3120, 2, 2753, 1, -1);
        run_a(4, 20, 100, 0, 0, -1);
        run_a(1, 20, 2, 1, 1, 1);
        run_a(0, 20, 2, 0, 0, 0);
        run_a(23, 20, 2, 7, 1, -1);
        run_a(5, 0, 2, 0, 0, 1);
        run_a(0, 1, 2, 0, 1, 0);
        run_a(65537, 64'hFFFF_FFFE, 2, -1, 1, -1);
        run_a(64'hFFFF_FFFF, 64'hFFFF_FFFE, 2, 1, 1, -1);

        // Abort mid-divide, then restart from a clean IDLE.
        start_a(17, 3120);
        repeat (19) begin
            en_a = 1'($urandom); tick();
        end
        chk("w32 busy before abort", longint'(busy_a), 1);
        reset_a();
        run_a(3, 20, 2, 7, 1, 3);

        for (int i = 0; i < 1000; i++)
            run_b(longint'($urandom_range(0, 255)),
                  longint'($urandom_range(2, 255)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
